// File: rtl/execute_pkg.sv
// Shared opcode and multiply/divide unit definitions for the execute stage.
package execute_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLT   = 4'd6,
    ALU_SLTU  = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_MULTU = 4'd11,
    ALU_DIVU  = 4'd12,
    ALU_MFHI  = 4'd13,
    ALU_MFLO  = 4'd14
  } alu_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_RUN  = 1'b1
  } md_state_e;

  localparam logic [4:0] MD_LAST_STEP = 5'd31;

  function automatic logic is_muldiv_op(input alu_op_e op);
    return (op == ALU_MULTU) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_hilo_read_op(input alu_op_e op);
    return (op == ALU_MFHI) || (op == ALU_MFLO);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle, 32 cycles.
module muldiv_unit
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        isDiv,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state;
  logic [4:0]  r_count;
  logic        r_isDiv;
  logic [31:0] r_b;
  logic [63:0] r_acc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [32:0] w_msum;
  logic [32:0] w_dshift;
  logic        w_dge;
  logic [31:0] w_dsub;
  logic [63:0] w_next;

  // Multiply: r_acc = {partial product, remaining multiplier bits}.
  // Divide:   r_acc = {partial remainder, dividend bits shifting into quotient}.
  // A zero divisor always subtracts, yielding all-ones quotient and remainder = a.
  assign w_msum   = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_dshift = {r_acc[63:32], r_acc[31]};
  assign w_dge    = (w_dshift >= {1'b0, r_b});
  assign w_dsub   = w_dshift[31:0] - r_b;

  always_comb begin
    w_next = '0;
    if (r_isDiv) begin
      if (w_dge) w_next = {w_dsub, r_acc[30:0], 1'b1};
      else       w_next = {w_dshift[31:0], r_acc[30:0], 1'b0};
    end else begin
      w_next = {w_msum, r_acc[31:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_count <= '0;
      r_isDiv <= 1'b0;
      r_b     <= '0;
      r_acc   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (start) begin
            r_acc   <= {32'd0, a};
            r_b     <= b;
            r_isDiv <= isDiv;
            r_count <= '0;
            r_state <= MD_RUN;
          end
        end
        MD_RUN: begin
          r_acc   <= w_next;
          r_count <= r_count + 5'd1;
          if (r_count == MD_LAST_STEP) begin
            r_hi    <= w_next[63:32];
            r_lo    <= w_next[31:0];
            r_state <= MD_IDLE;
          end
        end
        default: r_state <= MD_IDLE;
      endcase
    end
  end

  assign busy = (r_state == MD_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle ALU, HI/LO multiply/divide unit and EX/MEM register.
module execute
  import execute_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        validInput,
  input  logic        flushInput,
  input  logic        memToRegInput,
  input  logic        regWriteInput,
  input  logic        memWriteInput,
  input  logic        memReadInput,
  input  logic        aluSrcInput,
  input  logic [3:0]  aluOpInput,
  input  logic [31:0] readData1Input,
  input  logic [31:0] readData2Input,
  input  logic [31:0] immediateInput,
  input  logic [4:0]  shamtInput,
  input  logic [4:0]  regWriteAddressInput,
  output logic        stallOutput,
  output logic        memToRegOutput,
  output logic        regWriteOutput,
  output logic        memWriteOutput,
  output logic        memReadOutput,
  output logic [31:0] aluResultOutput,
  output logic [31:0] memWriteDataOutput,
  output logic [4:0]  regWriteAddressOutput,
  output logic        busyOutput
);

  alu_op_e     w_op;
  logic [31:0] w_opB;
  logic        w_isMd;
  logic        w_isMf;
  logic        w_busy;
  logic        w_issue;
  logic        w_start;
  logic        w_writeback;
  logic [31:0] w_hi;
  logic [31:0] w_lo;
  logic [31:0] w_result;

  assign w_op   = alu_op_e'(aluOpInput);
  assign w_opB  = aluSrcInput ? immediateInput : readData2Input;
  assign w_isMd = is_muldiv_op(w_op);
  assign w_isMf = is_hilo_read_op(w_op);

  assign stallOutput = validInput && !flushInput && w_busy && (w_isMd || w_isMf);
  assign w_issue     = validInput && !flushInput && !stallOutput;
  // Mul/div starts occupy no EX/MEM slot, so they retire as a bubble.
  assign w_start     = w_issue && w_isMd;
  assign w_writeback = w_issue && !w_isMd;

  muldiv_unit u_muldiv (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .isDiv (w_op == ALU_DIVU),
    .a     (readData1Input),
    .b     (w_opB),
    .busy  (w_busy),
    .hi    (w_hi),
    .lo    (w_lo)
  );

  always_comb begin
    w_result = '0;
    case (w_op)
      ALU_ADD:  w_result = readData1Input + w_opB;
      ALU_SUB:  w_result = readData1Input - w_opB;
      ALU_AND:  w_result = readData1Input & w_opB;
      ALU_OR:   w_result = readData1Input | w_opB;
      ALU_XOR:  w_result = readData1Input ^ w_opB;
      ALU_NOR:  w_result = ~(readData1Input | w_opB);
      ALU_SLT:  w_result = {31'd0, $signed(readData1Input) < $signed(w_opB)};
      ALU_SLTU: w_result = {31'd0, readData1Input < w_opB};
      ALU_SLL:  w_result = readData2Input << shamtInput;
      ALU_SRL:  w_result = readData2Input >> shamtInput;
      ALU_SRA:  w_result = $unsigned($signed(readData2Input) >>> shamtInput);
      ALU_MFHI: w_result = w_hi;
      ALU_MFLO: w_result = w_lo;
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || !w_writeback) begin
      memToRegOutput        <= 1'b0;
      regWriteOutput        <= 1'b0;
      memWriteOutput        <= 1'b0;
      memReadOutput         <= 1'b0;
      aluResultOutput       <= '0;
      memWriteDataOutput    <= '0;
      regWriteAddressOutput <= '0;
    end else begin
      memToRegOutput        <= memToRegInput;
      regWriteOutput        <= regWriteInput;
      memWriteOutput        <= memWriteInput;
      memReadOutput         <= memReadInput;
      aluResultOutput       <= w_result;
      memWriteDataOutput    <= readData2Input;
      regWriteAddressOutput <= regWriteAddressInput;
    end
  end

  assign busyOutput = w_busy;

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 Ports (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- validInput  in  1  instruction present in ID/EX
- flushInput  in  1  squash current instruction
- memToRegInput, regWriteInput, memWriteInput, memReadInput, aluSrcInput  in  1 each  decoded controls
- aluOpInput  in  4  operation code from shared package
- readData1Input, readData2Input, immediateInput  in  32 each  operands (immediate pre-extended)
- shamtInput  in  5  shift amount
- regWriteAddressInput  in  5  destination register
- stallOutput  out  1  upstream must hold inputs
- memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput  out  1 each  registered controls to memory stage
- aluResultOutput, memWriteDataOutput  out  32 each  registered result / store data
- regWriteAddressOutput  out  5  registered destination
- busyOutput  out  1  mul/div unit running

Function
REQ-003 SHALL register all memory-stage outputs (EX/MEM boundary); latency 1 cycle for single-cycle ops.
REQ-004 SHALL take operand B = immediateInput when aluSrcInput=1, else readData2Input; memWriteDataOutput SHALL take readData2Input.
REQ-005 Single-cycle ops: ADD/SUB modulo 2^32 (no overflow trap); AND, OR, XOR, NOR; SLT signed; SLTU unsigned; SLL/SRL/SRA of readData2Input by shamtInput; result is 1 or 0 zero-extended for SLT/SLTU.
REQ-006 MULTU: {HI,LO} = unsigned A*B (64-bit); DIVU: LO = A/B, HI = A%B unsigned; both iterative, one bit per cycle, 32 cycles.
REQ-007 DIVU with B=0 SHALL give LO=0xFFFFFFFF, HI=A, still 32 cycles.
REQ-008 MULTU/DIVU accepted only when unit idle, validInput=1, flushInput=0; accept edge latches operands, sets busy; output register loads a bubble (all four controls 0).
REQ-009 Unit SHALL be in IDLE or RUN; counter 0..31 in RUN; on the edge with counter=31: write HI/LO, clear busy, return to IDLE.
REQ-010 MFHI/MFLO SHALL return HI/LO as aluResultOutput with controls passed through; earliest issue is the cycle after busy clears.
REQ-011 stallOutput SHALL be combinational: 1 when validInput=1, flushInput=0, busy=1 and aluOp is MULTU, DIVU, MFHI or MFLO; else 0.
REQ-012 While stalled, output register SHALL load a bubble; upstream holds inputs; other ops issue normally during RUN.
REQ-013 flushInput=1 SHALL load a bubble and SHALL NOT start the unit; an operation already in RUN continues to completion.
REQ-014 validInput=0 SHALL load a bubble.

Reset
REQ-015 Reset SHALL clear all outputs to 0, HI=LO=0, state IDLE, counter 0, busy 0; reset mid-RUN aborts the operation with no HI/LO update.

Structure
REQ-016 aluOp enumeration (ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, MULTU, DIVU, MFHI, MFLO) and the unit state type SHALL live in a shared package.
REQ-017 Iterative multiply/divide with HI/LO SHALL be one sub-module, muldiv_unit (start, isDiv, a, b -> busy, hi, lo).

Verification
REQ-018 ADD A=5, B=0xFFFFFFFD -> aluResultOutput=2 next cycle; SLT 0xFFFFFFFF vs 1 -> 1; SLTU same -> 0.
REQ-019 MULTU 0xFFFFFFFF*2 then MFHI, MFLO -> MFHI stalled 32 cycles, then HI=1, LO=0xFFFFFFFE.
REQ-020 DIVU 100/7 -> LO=14, HI=2; DIVU 9/0 -> LO=0xFFFFFFFF, HI=9.
REQ-021 MULTU 7*6 followed by three ADDs -> ADDs issue unstalled during RUN; MFLO later -> 42.
REQ-022 Reset asserted at counter=15 of MULTU -> busy=0, HI=LO=0, next MFLO returns 0 without stall.
REQ-023 MULTU with flushInput=1 -> busy stays 0, bubble output, HI/LO unchanged.
